// File: rtl/datapath_sequencer_if.sv
// Bundles the instruction handshake and the register-file/ALU signals of the
// datapath sequencer. The sequencer uses the slave modport; a driver uses master.
interface datapath_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SEL_W  = 5
);
  logic              run;
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [ADDR_W-1:0] AA;
  logic [ADDR_W-1:0] BA;
  logic [ADDR_W-1:0] DA;
  logic              WR;
  logic [DATA_W-1:0] D;
  logic [SEL_W-1:0]  S;
  logic [DATA_W-1:0] F;
  logic              V;
  logic              C;
  logic              N;
  logic              Z;
  logic [3:0]        flags;
  logic              done;
  logic [15:0]       instr_count;

  modport master (
    output run, instr_valid, instr, F, V, C, N, Z,
    input  instr_ready, AA, BA, DA, WR, D, S, flags, done, instr_count
  );

  modport slave (
    input  run, instr_valid, instr, F, V, C, N, Z,
    output instr_ready, AA, BA, DA, WR, D, S, flags, done, instr_count
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) that takes one instruction word at a
// time, drives register-file addresses and ALU select, and writes back the result.
module datapath_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SEL_W  = 5
) (
  input logic                  clock,
  input logic                  reset,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        flags_q;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              accept;

  logic [ADDR_W-1:0] aa_w, ba_w, da_w;
  logic [SEL_W-1:0]  s_w;

  assign accept = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // WR and done derive from the state register, so an async reset drops them at once.
  always_comb begin
    bus.instr_ready = (state_q == IDLE) && bus.run;
    bus.WR          = (state_q == WB) && instr_q[1];
    bus.done        = (state_q == WB);
  end

  assign instr_count_d = instr_count_q + 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q       <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      instr_count_q <= '0;
    end else begin
      if (state_q == IDLE && accept) instr_q <= bus.instr;
      if (state_q == EXEC) begin
        result_q <= bus.F;
        if (instr_q[0]) flags_q <= {bus.V, bus.C, bus.N, bus.Z};
      end
      if (state_q == WB) instr_count_q <= instr_count_d;
    end
  end

  // Addresses come straight from the latched word, which holds its value while idle.
  assign s_w  = instr_q[15:11];
  assign da_w = instr_q[10:8];
  assign aa_w = instr_q[7:5];
  assign ba_w = instr_q[4:2];

  assign bus.S           = s_w;
  assign bus.DA          = da_w;
  assign bus.AA          = aa_w;
  assign bus.BA          = ba_w;
  assign bus.D           = result_q;
  assign bus.flags       = flags_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed self-checking bench for datapath_sequencer: handshake timing, write-back,
// flag latching, back-to-back throughput, async reset and counter wrap.
module tb_datapath_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  datapath_sequencer_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(5)) bus ();

  datapath_sequencer #(.DATA_W(16), .ADDR_W(3), .SEL_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] word,
                               input logic [15:0] aluF, input logic [3:0] vcnz);
    bus.instr_valid = valid;
    bus.instr       = word;
    bus.F           = aluF;
    {bus.V, bus.C, bus.N, bus.Z} = vcnz;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  logic [4:0]  expS [3];
  logic [15:0] queue [3];

  initial begin
    checks = 0;
    errors = 0;
    expS  = '{5'd2, 5'd4, 5'd6};
    queue = '{16'h1000, 16'h2000, 16'h3000};
    reset   = 1'b0;
    bus.run = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'h0);

    tick();
    tick();
    checkOutput("rst_ready", bus.instr_ready, 0);
    checkOutput("rst_wr",    bus.WR, 0);
    checkOutput("rst_done",  bus.done, 0);
    checkOutput("rst_addr",  {bus.AA, bus.BA, bus.DA}, 0);
    checkOutput("rst_s",     bus.S, 0);
    checkOutput("rst_d",     bus.D, 0);
    checkOutput("rst_flags", bus.flags, 0);
    checkOutput("rst_count", bus.instr_count, 0);

    reset = 1'b1;
    tick();
    checkOutput("run0_ready", bus.instr_ready, 0);
    bus.run = 1'b1;
    #1;
    checkOutput("first_ready", bus.instr_ready, 1);

    // Instruction 0x0A45: S=1 DA=2 AA=2 BA=1 wb_en=0 fl_en=1
    applyStimulus(1'b1, 16'h0A45, 16'h00AA, 4'b1010);
    tick();
    applyStimulus(1'b1, 16'hFFFF, 16'h00AA, 4'b1010);
    #1;
    checkOutput("A_read_ready", bus.instr_ready, 0);
    checkOutput("A_read_ops",   {bus.AA, bus.BA, bus.S}, {3'd2, 3'd1, 5'd1});
    checkOutput("A_read_wr",    bus.WR, 0);
    tick();
    checkOutput("A_exec_ops",   {bus.AA, bus.BA, bus.S}, {3'd2, 3'd1, 5'd1});
    checkOutput("A_exec_flags", bus.flags, 0);
    tick();
    applyStimulus(1'b0, 16'hFFFF, 16'h0000, 4'b0000);
    checkOutput("A_wb_ops",   {bus.AA, bus.BA, bus.S}, {3'd2, 3'd1, 5'd1});
    checkOutput("A_wb_done",  bus.done, 1);
    checkOutput("A_wb_wr",    bus.WR, 0);
    checkOutput("A_wb_flags", bus.flags, 4'b1010);
    checkOutput("A_wb_d",     bus.D, 16'h00AA);
    tick();
    checkOutput("A_idle_done",  bus.done, 0);
    checkOutput("A_idle_count", bus.instr_count, 1);
    checkOutput("A_idle_ready", bus.instr_ready, 1);
    checkOutput("A_idle_hold",  {bus.AA, bus.BA, bus.S}, {3'd2, 3'd1, 5'd1});

    // Instruction 0x1D2A: S=3 DA=5 AA=1 BA=2 wb_en=1 fl_en=0
    applyStimulus(1'b1, 16'h1D2A, 16'h1234, 4'b1111);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h1234, 4'b1111);
    tick();
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'b0000);
    checkOutput("B_wb_wr",    bus.WR, 1);
    checkOutput("B_wb_da",    bus.DA, 5);
    checkOutput("B_wb_d",     bus.D, 16'h1234);
    checkOutput("B_wb_flags", bus.flags, 4'b1010);
    tick();
    checkOutput("B_idle_wr",    bus.WR, 0);
    checkOutput("B_idle_ready", bus.instr_ready, 1);
    checkOutput("B_idle_count", bus.instr_count, 2);

    // Three queued instructions with instr_valid held high throughout
    applyStimulus(1'b1, queue[0], 16'h0000, 4'b0000);
    for (int t = 1; t <= 12; t++) begin
      tick();
      checkOutput($sformatf("C_ready_t%0d", t), bus.instr_ready, (t % 4 == 0));
      checkOutput($sformatf("C_done_t%0d", t),  bus.done, (t % 4 == 3));
      if (t % 4 == 1) begin
        checkOutput($sformatf("C_sel_t%0d", t), bus.S, expS[t / 4]);
        bus.instr = (t / 4 < 2) ? queue[t / 4 + 1] : 16'h4000;
      end
    end
    bus.instr_valid = 1'b0;
    checkOutput("C_count", bus.instr_count, 5);

    // Reset asserted in the middle of a write-back
    applyStimulus(1'b1, 16'h1D2B, 16'h4321, 4'b1111);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h4321, 4'b1111);
    tick();
    tick();
    checkOutput("D_wb_wr",    bus.WR, 1);
    checkOutput("D_wb_flags", bus.flags, 4'b1111);
    checkOutput("D_wb_d",     bus.D, 16'h4321);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("D_async_wr",    bus.WR, 0);
    checkOutput("D_async_done",  bus.done, 0);
    checkOutput("D_async_flags", bus.flags, 0);
    checkOutput("D_async_count", bus.instr_count, 0);
    checkOutput("D_async_d",     bus.D, 0);
    checkOutput("D_async_da",    bus.DA, 0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("D_post_count", bus.instr_count, 0);
    checkOutput("D_post_ready", bus.instr_ready, 1);

    // run=0 blocks acceptance; counter wraps from 0xFFFF
    bus.run = 1'b0;
    applyStimulus(1'b1, 16'h0A44, 16'h0000, 4'b1111);
    #1;
    checkOutput("E_run0_ready", bus.instr_ready, 0);
    tick();
    tick();
    checkOutput("E_run0_aa",    bus.AA, 0);
    checkOutput("E_run0_count", bus.instr_count, 0);
    checkOutput("E_run0_done",  bus.done, 0);
    force dut.instr_count_q = 16'hFFFF;
    tick();
    release dut.instr_count_q;
    tick();
    checkOutput("E_preload", bus.instr_count, 16'hFFFF);
    bus.run = 1'b1;
    #1;
    checkOutput("E_run1_ready", bus.instr_ready, 1);
    tick();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'b1111);
    checkOutput("E_read_aa", bus.AA, 2);
    tick();
    tick();
    checkOutput("E_wb_done",  bus.done, 1);
    checkOutput("E_wb_flags", bus.flags, 0);
    tick();
    checkOutput("E_wrap_count", bus.instr_count, 16'h0000);
    checkOutput("E_idle_done",  bus.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
